rx_unstuff_shift: RTL and testbench



---
 rtl/rx_unstuff_shift.sv | 152 +++++++++++++++
 tb/tb_rx_unstuff_shift.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift
//   USB RX stage behind the NRZI decoder. On each shift_strobe it samples
//   d_decoded and drops stuffed bits, then assembles the data bits LSB-first
//   into bytes. It reports packet end, with a check for a partial final byte,
//   and it can report stuffing violations.
//
//   Optional feature macro: USB_RX_STUFF_ERR_EN
//     defined   : a stuffed-bit slot that samples 1 pulses stuff_err and
//                 parks the block in ERROR until rx_active drops.
//     undefined : the stuffed-bit slot is dropped whatever its value, and
//                 stuff_err is held at 0.
//
// Ports
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   rx_active    in   receive window; low forces IDLE
//   shift_strobe in   one-cycle sample pulse per bit period
//   d_decoded    in   decoded data bit
//   eop          in   end-of-packet level
//   rx_byte      out  last completed byte; holds until the next one
//   byte_valid   out  one-cycle pulse, rx_byte valid
//   packet_done  out  one-cycle pulse on the first eop in ACTIVE
//   align_err    out  with packet_done when a partial byte was pending
//   stuff_err    out  one-cycle pulse on a stuffing violation
module rx_unstuff_shift #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx_active,
  input  logic              shift_strobe,
  input  logic              d_decoded,
  input  logic              eop,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              packet_done,
  output logic              align_err,
  output logic              stuff_err
);

  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_d;
  logic [2:0]        ones_cnt, ones_d;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [DATA_W-1:0] rx_byte_d;
  logic [DATA_W-1:0] shifted;
  logic              stuff_pos;
  logic              bv_d, pd_d, ae_d, se_d;

  // New bits enter at the MSB, so the first bit received ends up in bit 0.
  assign shifted   = {d_decoded, shreg[DATA_W-1:1]};
  assign stuff_pos = (ones_cnt == 3'(STUFF_LEN));

  always_comb begin
    state_d   = state;
    ones_d    = ones_cnt;
    bit_d     = bit_cnt;
    shreg_d   = shreg;
    rx_byte_d = rx_byte;
    bv_d      = 1'b0;
    pd_d      = 1'b0;
    ae_d      = 1'b0;
    se_d      = 1'b0;

    case (state)
      S_IDLE: begin
        ones_d = '0;
        bit_d  = '0;
        if (rx_active) state_d = S_ACTIVE;
      end

      S_ACTIVE: begin
        // rx_active low wins over eop and strobe: a silent abort.
        if (!rx_active) begin
          state_d = S_IDLE;
          ones_d  = '0;
          bit_d   = '0;
        end else if (eop) begin
          state_d = S_DONE;
          pd_d    = 1'b1;
          ae_d    = (bit_cnt != '0);
          bit_d   = '0;
        end else if (shift_strobe) begin
          if (stuff_pos) begin
            ones_d = '0;
`ifdef USB_RX_STUFF_ERR_EN
            if (d_decoded) begin
              se_d    = 1'b1;
              state_d = S_ERROR;
            end
`endif
          end else begin
            shreg_d = shifted;
            ones_d  = d_decoded ? (ones_cnt + 3'd1) : '0;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              rx_byte_d = shifted;
              bv_d      = 1'b1;
              bit_d     = '0;
            end else begin
              bit_d = bit_cnt + 1'b1;
            end
          end
        end
      end

      S_DONE, S_ERROR: begin
        if (!rx_active) begin
          state_d = S_IDLE;
          ones_d  = '0;
          bit_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      packet_done <= 1'b0;
      align_err   <= 1'b0;
      stuff_err   <= 1'b0;
    end else begin
      state       <= state_d;
      ones_cnt    <= ones_d;
      bit_cnt     <= bit_d;
      shreg       <= shreg_d;
      rx_byte     <= rx_byte_d;
      byte_valid  <= bv_d;
      packet_done <= pd_d;
      align_err   <= ae_d;
      stuff_err   <= se_d;
    end
  end

endmodule

// File: tb/tb_rx_unstuff_shift.sv
module tb_rx_unstuff_shift;
  localparam int DATA_W    = 8;
  localparam int STUFF_LEN = 6;
`ifdef USB_RX_STUFF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rx_active = 1'b0;
  logic shift_strobe = 1'b0;
  logic d_decoded = 1'b0;
  logic eop = 1'b0;
  logic [DATA_W-1:0] rx_byte;
  logic byte_valid, packet_done, align_err, stuff_err;

  rx_unstuff_shift #(.DATA_W(DATA_W), .STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .n_rst(n_rst), .rx_active(rx_active),
    .shift_strobe(shift_strobe), .d_decoded(d_decoded), .eop(eop),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .packet_done(packet_done),
    .align_err(align_err), .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  val;
  } ev_t;

  ev_t byte_q[$];
  ev_t pd_q[$];
  ev_t se_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name, string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  // Reference model: packet-level view of the receiver built from the
  // stuffing rules. Called once per cycle with the inputs the DUT sees at
  // the next rising edge; results are due one cycle after that edge.
  bit m_in_pkt = 0;
  bit m_halted = 0;
  int m_run = 0;
  bit m_bits[$];

  function automatic void model_clear();
    m_in_pkt = 0;
    m_halted = 0;
    m_run    = 0;
    m_bits.delete();
  endfunction

  function automatic void model_step(bit ra, bit st, bit d, bit e);
    ev_t ev;
    ev.cyc = cyc + 1;
    ev.val = '0;
    if (!ra) begin
      model_clear();
      return;
    end
    if (m_halted) return;
    if (!m_in_pkt) begin
      m_in_pkt = 1;
      m_run = 0;
      m_bits.delete();
      return;
    end
    if (e) begin
      ev.val = (m_bits.size() != 0) ? 8'd1 : 8'd0;
      pd_q.push_back(ev);
      m_halted = 1;
      m_bits.delete();
      return;
    end
    if (!st) return;
    if (m_run == STUFF_LEN) begin
      m_run = 0;
      if (d && ERR_EN) begin
        ev.val = 8'd1;
        se_q.push_back(ev);
        m_halted = 1;
      end
      return;
    end
    m_bits.push_back(d);
    m_run = d ? m_run + 1 : 0;
    if (m_bits.size() == DATA_W) begin
      foreach (m_bits[i]) ev.val[i] = m_bits[i];
      byte_q.push_back(ev);
      m_bits.delete();
    end
  endfunction

  // Monitor: pops expectations whenever the DUT pulses an output.
  always @(negedge clk) begin
    ev_t ev;
    if (n_rst) begin
      if (byte_valid) begin
        if (byte_q.size() == 0) fail_now("byte_unexpected", $sformatf("got %0h expected none", rx_byte));
        else begin
          ev = byte_q.pop_front();
          check("byte_val", rx_byte, ev.val);
          check("byte_cyc", cyc, ev.cyc);
        end
      end
      if (packet_done) begin
        if (pd_q.size() == 0) fail_now("pd_unexpected", "got packet_done expected none");
        else begin
          ev = pd_q.pop_front();
          check("align_err", align_err, ev.val);
          check("pd_cyc", cyc, ev.cyc);
        end
      end else if (align_err) begin
        fail_now("align_alone", "got align_err expected none without packet_done");
      end
      if (stuff_err) begin
        if (se_q.size() == 0) fail_now("se_unexpected", "got stuff_err expected none");
        else begin
          ev = se_q.pop_front();
          check("se_cyc", cyc, ev.cyc);
        end
      end
      while (byte_q.size() != 0 && byte_q[0].cyc < cyc) begin
        ev = byte_q.pop_front();
        fail_now("byte_missing", $sformatf("got no pulse expected %0h", ev.val));
      end
      while (pd_q.size() != 0 && pd_q[0].cyc < cyc) begin
        ev = pd_q.pop_front();
        fail_now("pd_missing", "got no packet_done expected one");
      end
      while (se_q.size() != 0 && se_q[0].cyc < cyc) begin
        ev = se_q.pop_front();
        fail_now("se_missing", "got no stuff_err expected one");
      end
    end
  end

  int tx_run = 0;

  task automatic drive(bit ra, bit st, bit d, bit e);
    @(negedge clk);
    rx_active    = ra;
    shift_strobe = st;
    d_decoded    = d;
    eop          = e;
    model_step(ra, st, d, e);
  endtask

  task automatic send_bit(bit b);
    drive(1, 1, b, 0);
    repeat ($urandom_range(0, 2)) drive(1, 0, 1'($urandom_range(0, 1)), 0);
  endtask

  // Transmitter side: inserts a 0 after STUFF_LEN consecutive ones.
  task automatic tx_bit(bit b);
    send_bit(b);
    tx_run = b ? tx_run + 1 : 0;
    if (tx_run == STUFF_LEN) begin
      send_bit(0);
      tx_run = 0;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  // Strobe in the arming cycle carries a 1 that must be ignored.
  task automatic begin_packet();
    drive(1, 1, 1, 0);
    tx_run = 0;
  endtask

  task automatic end_packet(int hold);
    repeat (hold) drive(1, 0, 0, 1);
    drive(1, 1, 1, 0);
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 1, 1, 1);
  endtask

  initial begin
    logic [7:0] b;
    int nb, mode, nbits;

    repeat (2) @(negedge clk);
    check("reset_outputs", {rx_byte, byte_valid, packet_done, align_err, stuff_err}, 0);
    n_rst = 1'b1;
    model_step(0, 0, 0, 0);

    // 0xA5
    begin_packet();
    send_byte(8'hA5);
    end_packet(1);

    // 0xFF with one stuffed zero
    begin_packet();
    send_byte(8'hFF);
    end_packet(2);

    // 0x3F then 0x00
    begin_packet();
    send_byte(8'h3F);
    send_byte(8'h00);
    end_packet(3);

    // seven consecutive ones, then more traffic
    begin_packet();
    repeat (7) send_bit(1);
    tx_run = 0;
    send_byte(8'h5A);
    send_byte(8'h81);
    end_packet(1);

    // 0x12, three bits, eop held
    begin_packet();
    send_byte(8'h12);
    tx_bit(1); tx_bit(0); tx_bit(1);
    end_packet(3);

    // async reset after five bits, then a fresh 0xC3
    begin_packet();
    send_byte(8'h77);
    tx_bit(1); tx_bit(1); tx_bit(0); tx_bit(1); tx_bit(0);
    @(negedge clk);
    shift_strobe = 1'b0;
    eop = 1'b0;
    #2 n_rst = 1'b0;
    model_clear();
    #1 check("reset_mid_packet", {rx_byte, byte_valid, packet_done, align_err, stuff_err}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_step(rx_active, 0, 0, 0);
    tx_run = 0;
    send_byte(8'hC3);
    end_packet(1);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      begin_packet();
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b = 8'hFF;
        send_byte(b);
      end
      mode = $urandom_range(0, 3);
      case (mode)
        0: end_packet($urandom_range(1, 3));
        1: begin
          nbits = $urandom_range(1, 7);
          for (int k = 0; k < nbits; k++) tx_bit(1'($urandom_range(0, 1)));
          end_packet($urandom_range(1, 3));
        end
        2: begin
          nbits = $urandom_range(1, 7);
          for (int k = 0; k < nbits; k++) tx_bit(1'($urandom_range(0, 1)));
          drive(0, 1, 1, 0);
          drive(0, 0, 0, 0);
        end
        default: begin
          nbits = $urandom_range(8, 24);
          for (int k = 0; k < nbits; k++) send_bit($urandom_range(0, 4) != 0);
          end_packet($urandom_range(1, 2));
        end
      endcase
    end

    repeat (5) drive(0, 0, 0, 0);
    check("byte_q_drained", byte_q.size(), 0);
    check("pd_q_drained", pd_q.size(), 0);
    check("se_q_drained", se_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
